// File: rtl/apb_master_pkg.sv
// Package: apb_master_pkg
// Shared definitions for the APB requester and the APB peripherals that sit
// behind it: transfer-state encodings and default bus widths.
package apb_master_pkg;

  // Transfer phases of an APB3 requester. Encodings are shared with the
  // peripherals so that state probes read the same across the bus.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADR_W_DEF = 32;
  localparam int APB_DAT_W_DEF = 32;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Module: apb_timeout_cnt
// Counts ACCESS cycles spent waiting on PREADY. The expired flag is raised
// combinationally in the cycle whose count-enable would bring the count up to
// `limit`, so the requester leaves ACCESS on that same edge. The ACCESS phase
// therefore lasts exactly `limit` wait cycles before the abort.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (asserted when a command is accepted)
//   enable     : one more wait cycle elapsed (ACCESS with PREADY low)
//   limit      : number of wait cycles tolerated
//   expired    : abort request for the current cycle
module apb_timeout_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = enable && (cnt_q == (limit - 1'b1));

endmodule

// File: rtl/apb_master.sv
// Module: apb_master
// APB3 requester. Turns a valid/ready command port into APB SETUP/ACCESS
// transfers and returns read data and error status on a one-cycle response
// strobe. One transfer outstanding at a time; responses cannot be stalled.
//
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYC cycles of PREADY low (response reports RSP_ERR=1, RSP_RDATA=0).
// Without it the requester waits on PREADY indefinitely.
//
// Ports:
//   PCLK, PRESETn            : clock, asynchronous active-low reset
//   CMD_VALID/READY          : command handshake (READY high only when idle)
//   CMD_WRITE/ADDR/WDATA     : command fields, captured on acceptance
//   RSP_VALID                : one-cycle completion strobe
//   RSP_RDATA/RSP_ERR        : completion result, held until the next one
//   PADDR/PSEL/PENABLE/
//   PWRITE/PWDATA            : APB request signals
//   PREADY/PRDATA/PSLVERR    : APB completer signals
module apb_master
  import apb_master_pkg::*;
#(
  parameter int ADR_W       = APB_ADR_W_DEF,
  parameter int DAT_W       = APB_DAT_W_DEF,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_WRITE,
  input  logic [ADR_W-1:0] CMD_ADDR,
  input  logic [DAT_W-1:0] CMD_WDATA,
  output logic             RSP_VALID,
  output logic [DAT_W-1:0] RSP_RDATA,
  output logic             RSP_ERR,
  output logic [ADR_W-1:0] PADDR,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [DAT_W-1:0] PWDATA,
  input  logic             PREADY,
  input  logic [DAT_W-1:0] PRDATA,
  input  logic             PSLVERR
);

  apb_state_e       state_q, state_d;
  logic             cmd_accept;
  logic             xfer_done;
  logic             xfer_abort;
  logic             timeout_hit;

  logic [ADR_W-1:0] paddr_q;
  logic             pwrite_q;
  logic [DAT_W-1:0] pwdata_q;
  logic             rsp_valid_q;
  logic [DAT_W-1:0] rsp_rdata_q;
  logic             rsp_err_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_accept = 1'b0;
    xfer_done  = 1'b0;
    xfer_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          cmd_accept = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A completer that answers in the very cycle the timeout fires wins.
        if (PREADY) begin
          xfer_done = 1'b1;
          state_d   = ST_IDLE;
        end else if (timeout_hit) begin
          xfer_abort = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  apb_timeout_cnt #(
    .CNT_W (CNT_W)
  ) u_timeout_cnt (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (cmd_accept),
    .enable  ((state_q == ST_ACCESS) && !PREADY),
    .limit   (CNT_W'(TIMEOUT_CYC)),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Request fields are captured once at acceptance and stay stable through
  // SETUP and ACCESS. PWDATA keeps its previous value across reads.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else if (cmd_accept) begin
      paddr_q  <= CMD_ADDR;
      pwrite_q <= CMD_WRITE;
      if (CMD_WRITE) begin
        pwdata_q <= CMD_WDATA;
      end
    end
  end

  // Completion: PRDATA/PSLVERR are only looked at on the ACCESS edge with
  // PREADY high. Writes and aborts return zero data.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= xfer_done || xfer_abort;
      if (xfer_done) begin
        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
        rsp_err_q   <= PSLVERR;
      end else if (xfer_abort) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  // PSEL/PENABLE decode straight from the state register so that an
  // asynchronous reset drops them immediately.
  assign CMD_READY = (state_q == ST_IDLE);
  assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: directed transfers with a response scoreboard.
module tb_apb_master;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int TO    = 8;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic             CMD_WRITE;
  logic [ADR_W-1:0] CMD_ADDR;
  logic [DAT_W-1:0] CMD_WDATA;
  logic             RSP_VALID;
  logic [DAT_W-1:0] RSP_RDATA;
  logic             RSP_ERR;
  logic [ADR_W-1:0] PADDR;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [DAT_W-1:0] PWDATA;
  logic             PREADY;
  logic [DAT_W-1:0] PRDATA;
  logic             PSLVERR;

  apb_master #(
    .ADR_W       (ADR_W),
    .DAT_W       (DAT_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_WRITE (CMD_WRITE),
    .CMD_ADDR  (CMD_ADDR),
    .CMD_WDATA (CMD_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [DAT_W-1:0] rdata;
    logic             err;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic w, input logic [DAT_W-1:0] prd, input logic err);
    rsp_t e;
    e.rdata = w ? '0 : prd;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    rsp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, RSP_RDATA, e.rdata);
      chk({tag, "_err"}, RSP_ERR, e.err);
    end
  endtask

  // Called just after a falling edge. Returns 1ns after the accepting edge.
  task automatic send(input logic w, input logic [ADR_W-1:0] a, input logic [DAT_W-1:0] d,
                      input bit hold);
    bit ok = 0;
    CMD_VALID = 1'b1;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_WDATA = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (CMD_READY) begin
        @(posedge PCLK);
        #1;
        if (!hold) CMD_VALID = 1'b0;
        ok = 1;
      end else begin
        @(negedge PCLK);
      end
    end
    if (!ok) chk("accept_bound", 64'd0, 64'd1);
  endtask

  // Full transfer with `waits` PREADY-low ACCESS cycles.
  task automatic xfer(input string tag, input logic w, input logic [ADR_W-1:0] a,
                      input logic [DAT_W-1:0] d, input int waits,
                      input logic [DAT_W-1:0] prd, input logic err);
    int acc = 0;
    bit done = 0;
    bit bad  = 0;
    sb_push(w, prd, err);
    @(negedge PCLK);
    send(w, a, d, 0);
    @(negedge PCLK);
    chk({tag, "_setup_psel"}, PSEL, 1'b1);
    chk({tag, "_setup_penable"}, PENABLE, 1'b0);
    PREADY  = 1'b0;
    PRDATA  = prd;
    PSLVERR = err;
    for (int i = 0; i < waits + 20 && !done; i++) begin
      @(negedge PCLK);
      if (RSP_VALID) begin
        done = 1;
      end else begin
        acc++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== a || PWRITE !== w) bad = 1;
        if (w && PWDATA !== d) bad = 1;
        PREADY = (acc == waits + 1);
      end
    end
    PREADY = 1'b0;
    if (!done) chk({tag, "_rsp_bound"}, 64'd0, 64'd1);
    chk({tag, "_access_cycles"}, acc, waits + 1);
    chk({tag, "_access_stable"}, bad, 1'b0);
    chk({tag, "_rsp_psel"}, PSEL, 1'b0);
    sb_check(tag);
    @(negedge PCLK);
    chk({tag, "_rsp_pulse"}, RSP_VALID, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  seen;
    PRESETn   = 1'b0;
    CMD_VALID = 1'b0;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = '0;
    CMD_WDATA = '0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 1'b0;

    // Reset state
    #12;
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_rdata", RSP_RDATA, 0);
    chk("rst_rsp_err", RSP_ERR, 1'b0);
    chk("rst_cmd_ready", CMD_READY, 1'b1);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // 1: zero-wait write
    xfer("t1_wr", 1'b1, 32'h000, 32'hA5, 0, 32'hFFFF_FFFF, 1'b0);

    // 2: read with 3 wait states; result holds afterwards
    xfer("t2_rd", 1'b0, 32'h004, 32'h0, 3, 32'h1234_5678, 1'b0);
    repeat (3) @(negedge PCLK);
    chk("t2_hold_rdata", RSP_RDATA, 32'h1234_5678);

    // 3: slave error, then a clean read clears it
    xfer("t3_err", 1'b1, 32'h00C, 32'h77, 0, 32'h0, 1'b1);
    xfer("t3_ok", 1'b0, 32'h000, 32'h0, 1, 32'hCAFE_F00D, 1'b0);

    // 4: two commands presented back to back with CMD_VALID held
    sb_push(1'b1, 32'h0000_55AA, 1'b0);
    sb_push(1'b0, 32'h0000_55AA, 1'b0);
    PREADY  = 1'b1;
    PRDATA  = 32'h0000_55AA;
    PSLVERR = 1'b0;
    @(negedge PCLK);
    send(1'b1, 32'h010, 32'h11, 0);
    CMD_VALID = 1'b1;
    CMD_WRITE = 1'b0;
    CMD_ADDR  = 32'h014;
    @(negedge PCLK);
    chk("t4_a_setup_paddr", PADDR, 32'h010);
    chk("t4_a_setup_ready", CMD_READY, 1'b0);
    chk("t4_a_setup_penable", PENABLE, 1'b0);
    @(negedge PCLK);
    chk("t4_a_access_penable", PENABLE, 1'b1);
    chk("t4_a_access_paddr", PADDR, 32'h010);
    chk("t4_a_access_ready", CMD_READY, 1'b0);
    @(negedge PCLK);
    chk("t4_a_rsp_valid", RSP_VALID, 1'b1);
    chk("t4_a_rsp_ready", CMD_READY, 1'b1);
    sb_check("t4_a");
    @(posedge PCLK);
    #1;
    CMD_VALID = 1'b0;
    @(negedge PCLK);
    chk("t4_b_setup_psel", PSEL, 1'b1);
    chk("t4_b_setup_penable", PENABLE, 1'b0);
    chk("t4_b_setup_paddr", PADDR, 32'h014);
    chk("t4_b_setup_pwrite", PWRITE, 1'b0);
    @(negedge PCLK);
    chk("t4_b_access_penable", PENABLE, 1'b1);
    @(negedge PCLK);
    chk("t4_b_rsp_valid", RSP_VALID, 1'b1);
    sb_check("t4_b");
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("t4_b_rsp_pulse", RSP_VALID, 1'b0);

    // 5: PREADY stuck low
`ifdef APB_TIMEOUT_EN
    sb_push(1'b1, 32'h0, 1'b1);
    PRDATA  = 32'hDEAD_BEEF;
    PSLVERR = 1'b0;
    @(negedge PCLK);
    send(1'b0, 32'h024, 32'h0, 0);
    @(negedge PCLK);
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge PCLK);
      if (RSP_VALID) seen = 1;
      else if (PSEL && PENABLE) cnt++;
    end
    chk("t5_to_seen", seen, 1'b1);
    chk("t5_to_access_cycles", cnt, TO);
    chk("t5_to_psel", PSEL, 1'b0);
    sb_check("t5_to");
`else
    sb_push(1'b1, 32'h0, 1'b0);
    @(negedge PCLK);
    send(1'b1, 32'h020, 32'h3C, 0);
    @(negedge PCLK);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && !RSP_VALID) cnt++;
    end
    chk("t5_stuck_cycles", cnt, 100);
    PREADY = 1'b1;
    @(negedge PCLK);
    PREADY = 1'b0;
    chk("t5_late_rsp_valid", RSP_VALID, 1'b1);
    sb_check("t5_late");
`endif

    // 6: asynchronous reset during ACCESS
    @(negedge PCLK);
    PREADY = 1'b0;
    send(1'b0, 32'h030, 32'h0, 0);
    @(negedge PCLK);
    @(negedge PCLK);
    chk("t6_in_access", PENABLE, 1'b1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("t6_async_psel", PSEL, 1'b0);
    chk("t6_async_penable", PENABLE, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (RSP_VALID) seen = 1;
    end
    chk("t6_no_rsp", seen, 1'b0);
    chk("t6_ready", CMD_READY, 1'b1);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
